// File: rtl/lbs_pkg.sv
// Shared types and defaults for the pipelined left barrel shifter (lbs).
// Optional right-direction support is selected with LBS_RIGHT_DIR_EN.
package lbs_pkg;

    typedef enum logic {
        LBS_ROT = 1'b0,
        LBS_SHL = 1'b1
    } lbs_mode_t;

    localparam int LBS_WIDTH_DEF = 32;

endpackage

// File: rtl/lbs_stage.sv
// One register stage of the barrel shifter: conditionally shifts by DIST on load.
// Carries the operand direction when LBS_RIGHT_DIR_EN is defined.
module lbs_stage
    import lbs_pkg::*;
#(
    parameter int WIDTH = LBS_WIDTH_DEF,
    parameter int SHW   = $clog2(WIDTH),
    parameter int DIST  = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             prev_valid,
    input  logic [WIDTH-1:0] prev_data,
    input  logic [SHW-1:0]   prev_shift,
    input  lbs_mode_t        prev_mode,
`ifdef LBS_RIGHT_DIR_EN
    input  logic             prev_dir,
    output logic             dir,
`endif
    input  logic             next_advance,
    output logic             advance,
    output logic             valid,
    output logic [WIDTH-1:0] data,
    output logic [SHW-1:0]   shift,
    output lbs_mode_t        mode
);

    localparam int BIT = $clog2(DIST);

    logic [WIDTH-1:0] ld_data;

    // An empty stage can always take new content, even while downstream is stalled.
    assign advance = !valid || next_advance;

    always_comb begin
        ld_data = prev_data;
        if (prev_shift[BIT]) begin
            if (prev_mode == LBS_ROT) begin
                ld_data = {prev_data[WIDTH-1-DIST:0], prev_data[WIDTH-1:WIDTH-DIST]};
            end else begin
                ld_data = {prev_data[WIDTH-1-DIST:0], {DIST{1'b0}}};
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= 1'b0;
            data  <= '0;
            shift <= '0;
            mode  <= LBS_ROT;
`ifdef LBS_RIGHT_DIR_EN
            dir   <= 1'b0;
`endif
        end else if (advance) begin
            valid <= prev_valid;
            if (prev_valid) begin
                data  <= ld_data;
                shift <= prev_shift;
                mode  <= prev_mode;
`ifdef LBS_RIGHT_DIR_EN
                dir   <= prev_dir;
`endif
            end
        end
    end

endmodule

// File: rtl/left_barrel_shifter_pipe.sv
// Pipelined left rotator / logical left shifter, one stage per shift-amount bit.
// Defining LBS_RIGHT_DIR_EN adds in_dir for right rotate/shift via bit reversal.
module left_barrel_shifter_pipe
    import lbs_pkg::*;
#(
    parameter int WIDTH = LBS_WIDTH_DEF,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [SHW-1:0]   in_shift,
    input  logic             in_mode,
`ifdef LBS_RIGHT_DIR_EN
    input  logic             in_dir,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
);

    // Handshake: a transfer happens on a cycle where valid && ready on that side.
    // Producers hold fields stable until accepted; in_ready is combinational from out_ready.

    // Index 0 is the input side; index k+1 is the output of stage k.
    logic             vld [SHW+1];
    logic [WIDTH-1:0] dat [SHW+1];
    logic [SHW-1:0]   sh  [SHW+1];
    lbs_mode_t        md  [SHW+1];
    logic             adv [SHW+1];

`ifdef LBS_RIGHT_DIR_EN
    logic             dr  [SHW+1];

    function automatic logic [WIDTH-1:0] bit_rev(input logic [WIDTH-1:0] d);
        logic [WIDTH-1:0] r;
        for (int i = 0; i < WIDTH; i++) begin
            r[i] = d[WIDTH-1-i];
        end
        return r;
    endfunction

    assign dr[0]    = in_dir;
    assign dat[0]   = in_dir ? bit_rev(in_data) : in_data;
    assign out_data = dr[SHW] ? bit_rev(dat[SHW]) : dat[SHW];
`else
    assign dat[0]   = in_data;
    assign out_data = dat[SHW];
`endif

    assign vld[0]    = in_valid;
    assign sh[0]     = in_shift;
    assign md[0]     = lbs_mode_t'(in_mode);
    assign adv[SHW]  = out_ready;
    assign in_ready  = adv[0];
    assign out_valid = vld[SHW];

    for (genvar k = 0; k < SHW; k++) begin : g_stage
        lbs_stage #(
            .WIDTH (WIDTH),
            .SHW   (SHW),
            .DIST  (1 << k)
        ) u_stage (
            .clk          (clk),
            .rst_n        (rst_n),
            .prev_valid   (vld[k]),
            .prev_data    (dat[k]),
            .prev_shift   (sh[k]),
            .prev_mode    (md[k]),
`ifdef LBS_RIGHT_DIR_EN
            .prev_dir     (dr[k]),
            .dir          (dr[k+1]),
`endif
            .next_advance (adv[k+1]),
            .advance      (adv[k]),
            .valid        (vld[k+1]),
            .data         (dat[k+1]),
            .shift        (sh[k+1]),
            .mode         (md[k+1])
        );
    end

endmodule

// File: tb/tb_left_barrel_shifter_pipe.sv
// Self-checking bench for left_barrel_shifter_pipe: vector table, random stream,
// backpressure, full stall and mid-flight reset, all checked through one scoreboard.
module tb_left_barrel_shifter_pipe;

    localparam int WIDTH = 32;
    localparam int SHW   = 5;

    logic             clk = 1'b0;
    logic             rst_n = 1'b1;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [WIDTH-1:0] in_data = '0;
    logic [SHW-1:0]   in_shift = '0;
    logic             in_mode = 1'b0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [WIDTH-1:0] out_data;
`ifdef LBS_RIGHT_DIR_EN
    logic             in_dir = 1'b0;
`endif

    left_barrel_shifter_pipe #(.WIDTH(WIDTH), .SHW(SHW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_shift  (in_shift),
        .in_mode   (in_mode),
`ifdef LBS_RIGHT_DIR_EN
        .in_dir    (in_dir),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    // ---------------- scoreboard state ----------------
    typedef struct {
        logic [WIDTH-1:0] d;
        logic [SHW-1:0]   sh;
        logic             m;
        logic [WIDTH-1:0] exp;
    } vec_t;

    vec_t             vecs [12];
    logic [WIDTH-1:0] exp_q [$];
    logic [WIDTH-1:0] cur_exp = '0;
    int               n_checks = 0;
    int               n_pass = 0;
    int               acc_cnt = 0;
    int               out_cnt = 0;
    bit               lat_arm = 1'b0;
    int               first_acc = -1;
    int               first_out = -1;
    int               last_out = -1;
    bit               rand_ready = 1'b0;
    bit               prev_stall = 1'b0;
    logic [WIDTH-1:0] prev_out = '0;

    function automatic logic [WIDTH-1:0] model(input logic [WIDTH-1:0] d,
                                               input logic [SHW-1:0] sh,
                                               input logic m);
        if (sh == 0) return d;
        if (m) return d << sh;
        return (d << sh) | (d >> (WIDTH - int'(sh)));
    endfunction

    task automatic check(input string name, input logic [WIDTH-1:0] act,
                         input logic [WIDTH-1:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    // Monitor: samples at negedge, where all handshake signals are settled.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (prev_stall) begin
                    check("hold_valid", 32'(out_valid), 32'd1);
                    check("hold_data", out_data, prev_out);
                end
                if (out_valid && out_ready) begin
                    if (exp_q.size() > 0) begin
                        check("out_data", out_data, exp_q.pop_front());
                    end else begin
                        n_checks++;
                        $display("FAIL spurious_out: got 0x%08h expected no output", out_data);
                    end
                    out_cnt++;
                    if (lat_arm) begin
                        if (first_out < 0) first_out = cyc;
                        last_out = cyc;
                    end
                end
                if (in_valid && in_ready) begin
                    exp_q.push_back(cur_exp);
                    acc_cnt++;
                    if (lat_arm && first_acc < 0) first_acc = cyc;
                end
                prev_stall = out_valid && !out_ready;
                prev_out   = out_data;
            end else begin
                prev_stall = 1'b0;
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rand_ready) out_ready = 1'($urandom_range(0, 1));
        end
    end

    // ---------------- driver tasks ----------------
    task automatic set_op(input logic [WIDTH-1:0] d, input logic [SHW-1:0] sh,
                          input logic m, input logic [WIDTH-1:0] e);
        in_valid = 1'b1;
        in_data  = d;
        in_shift = sh;
        in_mode  = m;
        cur_exp  = e;
    endtask

    task automatic set_rand_op();
        logic [WIDTH-1:0] d;
        logic [SHW-1:0]   sh;
        logic             m;
        d  = $urandom;
        sh = SHW'($urandom_range(0, WIDTH - 1));
        m  = 1'($urandom_range(0, 1));
        set_op(d, sh, m, model(d, sh, m));
    endtask

    task automatic go_idle();
        in_valid = 1'b0;
        in_data  = $urandom;
        in_shift = SHW'($urandom_range(0, WIDTH - 1));
        in_mode  = 1'($urandom_range(0, 1));
    endtask

    // Called at posedge+1; returns at posedge+1 right after the operand was accepted.
    task automatic send(input logic [WIDTH-1:0] d, input logic [SHW-1:0] sh,
                        input logic m, input logic [WIDTH-1:0] e);
        int t = 0;
        set_op(d, sh, m, e);
        @(negedge clk);
        while (!in_ready && t < 500) begin
            @(negedge clk);
            t++;
        end
        if (!in_ready) begin
            n_checks++;
            $display("FAIL send_timeout: got in_ready=0 expected 1 within 500 cycles");
        end
        @(posedge clk);
        #1;
        go_idle();
    endtask

    task automatic send_rand();
        logic [WIDTH-1:0] d;
        logic [SHW-1:0]   sh;
        logic             m;
        d  = $urandom;
        sh = SHW'($urandom_range(0, WIDTH - 1));
        m  = 1'($urandom_range(0, 1));
        send(d, sh, m, model(d, sh, m));
    endtask

    task automatic drain();
        int t = 0;
        rand_ready = 1'b0;
        out_ready  = 1'b1;
        while (exp_q.size() != 0 && t < 500) begin
            @(posedge clk);
            #1;
            t++;
        end
        check("drain_left", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
        repeat (3) @(posedge clk);
        #1;
        check("drained_valid", 32'(out_valid), 32'd0);
    endtask

    // ---------------- test sequence ----------------
    initial begin
        int acc0;
        int out0;
        bit was_ready;

        vecs[0]  = '{32'h8000_0001, 5'd1,  1'b0, 32'h0000_0003};
        vecs[1]  = '{32'h1234_5678, 5'd8,  1'b0, 32'h3456_7812};
        vecs[2]  = '{32'hFFFF_FFFF, 5'd31, 1'b1, 32'h8000_0000};
        vecs[3]  = '{32'hDEAD_BEEF, 5'd0,  1'b0, 32'hDEAD_BEEF};
        vecs[4]  = '{32'hDEAD_BEEF, 5'd0,  1'b1, 32'hDEAD_BEEF};
        vecs[5]  = '{32'h1234_5678, 5'd4,  1'b1, 32'h2345_6780};
        vecs[6]  = '{32'h0000_0002, 5'd31, 1'b0, 32'h0000_0001};
        vecs[7]  = '{32'hFFFF_FFFE, 5'd31, 1'b1, 32'h0000_0000};
        vecs[8]  = '{32'hF000_000F, 5'd16, 1'b0, 32'h000F_F000};
        vecs[9]  = '{32'hA5A5_A5A5, 5'd1,  1'b1, 32'h4B4B_4B4A};
        vecs[10] = '{32'h8000_0000, 5'd31, 1'b0, 32'h4000_0000};
        vecs[11] = '{32'h0000_0001, 5'd31, 1'b1, 32'h8000_0000};

        #2 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_out_valid", 32'(out_valid), 32'd0);
        check("reset_out_data", out_data, 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("reset_in_ready", 32'(in_ready), 32'd1);

        // Directed vectors, back to back.
        out_ready = 1'b1;
        for (int i = 0; i < 12; i++) begin
            send(vecs[i].d, vecs[i].sh, vecs[i].m, vecs[i].exp);
        end
        drain();

        // Full-rate stream: latency and gap-free output.
        lat_arm   = 1'b1;
        first_acc = -1;
        first_out = -1;
        out0      = out_cnt;
        for (int i = 0; i < 1000; i++) send_rand();
        drain();
        lat_arm = 1'b0;
        check("latency", 32'(first_out - first_acc), 32'(SHW));
        check("stream_count", 32'(out_cnt - out0), 32'd1000);
        check("stream_gapless", 32'(last_out - first_out), 32'd999);

        // Random producer gaps and random consumer backpressure.
        rand_ready = 1'b1;
        out0 = out_cnt;
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 1) == 1) begin
                @(posedge clk);
                #1;
            end
            send_rand();
        end
        drain();
        check("bp_count", 32'(out_cnt - out0), 32'd300);

        // Full stall: pipeline fills to SHW operands, then in_ready drops.
        out_ready = 1'b0;
        acc0 = acc_cnt;
        set_rand_op();
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            was_ready = in_ready;
            @(posedge clk);
            #1;
            if (was_ready) set_rand_op();
        end
        check("stall_in_ready", 32'(in_ready), 32'd0);
        check("stall_out_valid", 32'(out_valid), 32'd1);
        go_idle();
        check("stall_accepts", 32'(acc_cnt - acc0), 32'(SHW));
        out0 = out_cnt;
        drain();
        check("stall_drain_count", 32'(out_cnt - out0), 32'(SHW));

        // Reset with three operands in flight.
        out_ready = 1'b1;
        send_rand();
        send_rand();
        send_rand();
        rst_n = 1'b0;
        #1;
        check("midreset_out_valid", 32'(out_valid), 32'd0);
        check("midreset_out_data", out_data, 32'd0);
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("postreset_in_ready", 32'(in_ready), 32'd1);
        out0 = out_cnt;
        send(32'h0000_00F0, 5'd28, 1'b0, 32'h0000_000F);
        drain();
        check("postreset_count", 32'(out_cnt - out0), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
